instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 190 +++++++++++++++++++
 tb/tb_instruction_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues single-outstanding word reads to instruction
// memory, buffers returned words and hands them to decode over a valid/ready
// handshake. Redirects from execute flush the buffer and restart fetch.
//
// Build option: define FETCH_PREFETCH_EN for a 2-entry buffer (one fetch can
// be in flight while a word waits for decode). Without it the buffer holds a
// single entry and no request is issued while that entry is occupied.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [11:0] mem_addr,
  input  logic        mem_ack,
  input  logic [11:0] mem_rdata,
  output logic [11:0] instr,
  output logic [11:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [11:0] redirect_pc
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [1:0] Depth = 2'd2;
`else
  localparam logic [1:0] Depth = 2'd1;
`endif

  // StReq: a request is on the bus. StFull: no request, buffer full.
  // StIdle: no request, space available (transient, next edge issues).
  typedef enum logic [1:0] {StIdle, StReq, StFull} state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [11:0] mem_addr_q, mem_addr_d;
  logic        stale_q, stale_d;
  logic [1:0]  count_q, count_d;
  logic [11:0] ent0_data_q, ent0_data_d;
  logic [11:0] ent0_pc_q, ent0_pc_d;
`ifdef FETCH_PREFETCH_EN
  logic [11:0] ent1_data_q, ent1_data_d;
  logic [11:0] ent1_pc_q, ent1_pc_d;
`endif

  logic        pop;
  logic        ack_live;
  logic        push;
  logic        outstanding_next;
  logic [1:0]  count_after_pop;
  logic [11:0] pc_src;
  logic        can_issue;

  assign instr_valid = (count_q != 2'd0);
  assign instr       = ent0_data_q;
  assign instr_pc    = ent0_pc_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  // Handshake decode, occupancy and issue decision.
  always_comb begin
    pop              = instr_valid && instr_ready;
    // An ack with no request on the bus (e.g. one left over from before reset) is ignored.
    ack_live         = mem_req_q && mem_ack;
    // Stale returns and returns coinciding with a redirect are dropped.
    push             = ack_live && !stale_q && !redirect;
    outstanding_next = mem_req_q && !mem_ack;
    count_after_pop  = count_q - {1'b0, pop};
    count_d          = redirect ? 2'd0 : (count_after_pop + {1'b0, push});
    pc_src           = redirect ? redirect_pc : pc_q;
    // At most one in flight, and a slot must be free for the word it returns.
    can_issue        = !outstanding_next && (count_d < Depth);
  end

  // Stale tracking: a redirect while a request stays in flight poisons its return.
  always_comb begin
    stale_d = stale_q;
    if (redirect && outstanding_next) begin
      stale_d = 1'b1;
    end else if (ack_live) begin
      stale_d = 1'b0;
    end
  end

  // Fetch FSM next state; mem_req follows the StReq state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (can_issue) begin
          state_d = StReq;
        end else if (count_d == Depth) begin
          state_d = StFull;
        end
      end
      StReq: begin
        if (!outstanding_next) begin
          if (can_issue) begin
            state_d = StReq;
          end else if (count_d == Depth) begin
            state_d = StFull;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFull: begin
        if (can_issue) begin
          state_d = StReq;
        end else if (count_d != Depth) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Request address and fetch PC update.
  always_comb begin
    mem_req_d  = (state_d == StReq);
    mem_addr_d = can_issue ? pc_src : mem_addr_q;
    // pc_q always names the next address to fetch; wraps naturally at 12 bits.
    pc_d       = can_issue ? (pc_src + 12'd1) : pc_src;
  end

`ifdef FETCH_PREFETCH_EN
  // Two-entry shift buffer: entry 0 is the head presented to decode.
  always_comb begin
    ent0_data_d = ent0_data_q;
    ent0_pc_d   = ent0_pc_q;
    ent1_data_d = ent1_data_q;
    ent1_pc_d   = ent1_pc_q;
    if (pop) begin
      ent0_data_d = ent1_data_q;
      ent0_pc_d   = ent1_pc_q;
    end
    if (push) begin
      if (count_after_pop == 2'd0) begin
        ent0_data_d = mem_rdata;
        ent0_pc_d   = mem_addr_q;
      end else begin
        ent1_data_d = mem_rdata;
        ent1_pc_d   = mem_addr_q;
      end
    end
  end
`else
  // Single-entry buffer: a push always lands in the only slot.
  always_comb begin
    ent0_data_d = ent0_data_q;
    ent0_pc_d   = ent0_pc_q;
    if (push) begin
      ent0_data_d = mem_rdata;
      ent0_pc_d   = mem_addr_q;
    end
  end
`endif

  // All state, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= 12'h000;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 12'h000;
      stale_q     <= 1'b0;
      count_q     <= 2'd0;
      ent0_data_q <= 12'h000;
      ent0_pc_q   <= 12'h000;
`ifdef FETCH_PREFETCH_EN
      ent1_data_q <= 12'h000;
      ent1_pc_q   <= 12'h000;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      stale_q     <= stale_d;
      count_q     <= count_d;
      ent0_data_q <= ent0_data_d;
      ent0_pc_q   <= ent0_pc_d;
`ifdef FETCH_PREFETCH_EN
      ent1_data_q <= ent1_data_d;
      ent1_pc_q   <= ent1_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch. Memory returns
// addr ^ 12'h5A5 and acks in the same cycle as the request when enabled.
module tb_instruction_fetch;

`ifdef FETCH_PREFETCH_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif
  localparam int StreamCount = (Depth == 2) ? 8 : 4;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [11:0] mem_rdata;
  logic [11:0] instr;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [11:0] redirect_pc;

  logic        ack_en;
  logic        force_ack;
  int          checks;
  int          errors;

  assign mem_ack   = (mem_req & ack_en) | force_ack;
  assign mem_rdata = mem_addr ^ 12'h5A5;

  instruction_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ack_en = 1'b0; force_ack = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ack_en = 1'b0; force_ack = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    step(); step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mem_req); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    checks++; if (instr !== 12'h000) begin errors++; $display("FAIL rst_instr got %h exp 000", instr); end
    checks++; if (instr_pc !== 12'h000) begin errors++; $display("FAIL rst_pc got %h exp 000", instr_pc); end
    rst_n = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL first_addr got %h exp 000", mem_addr); end
  endtask

  task automatic test_stream;
    logic [11:0] exp_pc;
    logic [11:0] exp_addr;
    int          got;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_latency got %b exp 1", instr_valid); end
    exp_pc = 12'h000; exp_addr = 12'h001; got = 0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) begin
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc got %h exp %h", instr_pc, exp_pc); end
        checks++; if (instr !== (exp_pc ^ 12'h5A5)) begin errors++; $display("FAIL stream_instr got %h exp %h", instr, exp_pc ^ 12'h5A5); end
        exp_pc = exp_pc + 12'd1; got++;
      end
      if (mem_req) begin
        checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL stream_addr got %h exp %h", mem_addr, exp_addr); end
        exp_addr = exp_addr + 12'd1;
      end
      step();
    end
    checks++; if (got != StreamCount) begin errors++; $display("FAIL stream_count got %0d exp %0d", got, StreamCount); end
  endtask

  task automatic test_stall;
    int got;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid0 got %b exp 1", instr_valid); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", instr_valid); end
      checks++; if (instr_pc !== 12'h000) begin errors++; $display("FAIL stall_pc got %h exp 000", instr_pc); end
      checks++; if (instr !== 12'h5A5) begin errors++; $display("FAIL stall_instr got %h exp 5a5", instr); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq got %b exp 0", mem_req); end
    end
    ack_en = 1'b0; instr_ready = 1'b1; got = 0;
    for (int i = 0; i < 4; i++) begin
      if (instr_valid) begin
        checks++; if (instr_pc !== 12'(got)) begin errors++; $display("FAIL stall_drain_pc got %h exp %h", instr_pc, 12'(got)); end
        got++;
      end
      step();
    end
    checks++; if (got != Depth) begin errors++; $display("FAIL stall_buffered got %0d exp %0d", got, Depth); end
  endtask

  task automatic test_redirect_stale;
    bit found;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mem_req && mem_addr == 12'h005) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL stale_reach005 got none exp req 005"); end
    ack_en = 1'b0; redirect = 1'b1; redirect_pc = 12'h3A0;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_valid got %b exp 0", instr_valid); end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stale_hold_req got %b exp 1", mem_req); end
      checks++; if (mem_addr !== 12'h005) begin errors++; $display("FAIL stale_hold_addr got %h exp 005", mem_addr); end
      if (i == 2) ack_en = 1'b1;
      step();
    end
    checks++; if (mem_addr !== 12'h3A0) begin errors++; $display("FAIL stale_newaddr got %h exp 3a0", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stale_dropped got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stale_first_valid got %b exp 1", instr_valid); end
    checks++; if (instr_pc !== 12'h3A0) begin errors++; $display("FAIL stale_first_pc got %h exp 3a0", instr_pc); end
    checks++; if (instr !== 12'h605) begin errors++; $display("FAIL stale_first_instr got %h exp 605", instr); end
  endtask

  task automatic test_wrap;
    int          got;
    logic [11:0] e;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'hFFE;
    step();
    redirect = 1'b0;
    checks++; if (mem_addr !== 12'hFFE) begin errors++; $display("FAIL wrap_addr got %h exp ffe", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_ackdrop got %b exp 0", instr_valid); end
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid && got < 4) begin
        e = 12'hFFE + 12'(got);
        checks++; if (instr_pc !== e) begin errors++; $display("FAIL wrap_pc got %h exp %h", instr_pc, e); end
        got++;
      end
      step();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got); end
  endtask

  task automatic test_redirect_transfer;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (instr_pc !== 12'h000 || instr_valid !== 1'b1) begin errors++; $display("FAIL xfer_pre got %b/%h exp 1/000", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_pc = 12'h100;
    step();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL xfer_flush got %b exp 0", instr_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h100) begin errors++; $display("FAIL xfer_addr got %b/%h exp 1/100", mem_req, mem_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 12'h100) begin errors++; $display("FAIL xfer_next got %b/%h exp 1/100", instr_valid, instr_pc); end
    checks++; if (instr !== 12'h4A5) begin errors++; $display("FAIL xfer_instr got %h exp 4a5", instr); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    ack_en = 1'b1; instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 12'h111;
    step();
    redirect_pc = 12'h222;
    step();
    redirect = 1'b0;
    checks++; if (mem_addr !== 12'h222) begin errors++; $display("FAIL b2b_addr got %h exp 222", mem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_pc !== 12'h222 || instr_valid !== 1'b1) begin errors++; $display("FAIL b2b_pc got %b/%h exp 1/222", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    ack_en = 1'b1; redirect = 1'b1; redirect_pc = 12'h200;
    step();
    redirect = 1'b0; ack_en = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h200) begin errors++; $display("FAIL mid_pre got %b/%h exp 1/200", mem_req, mem_addr); end
    rst_n = 1'b0;
    step();
    checks++; if (mem_req !== 1'b0 || mem_addr !== 12'h000) begin errors++; $display("FAIL mid_rst got %b/%h exp 0/000", mem_req, mem_addr); end
    rst_n = 1'b1; force_ack = 1'b1;
    step();
    force_ack = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_lateack got %b exp 0", instr_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 12'h000) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/000", mem_req, mem_addr); end
    ack_en = 1'b1; instr_ready = 1'b1;
    step();
    checks++; if (instr_valid !== 1'b1 || instr !== 12'h5A5) begin errors++; $display("FAIL mid_first got %b/%h exp 1/5a5", instr_valid, instr); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; ack_en = 1'b0; force_ack = 1'b0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 12'h000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stale();
    test_wrap();
    test_redirect_transfer();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
